// File: rtl/jb_clk_pkg.sv
// Shared types and helpers for the bus clock generator.
package jb_clk_pkg;

  typedef enum logic [1:0] {
    POR    = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    HIGH_S = 2'd3
  } clk_state_t;

  // ceil(log2(n)), but never narrower than one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/jb_win_match.sv
// Parallel address-window compare with lowest-index priority.
module jb_win_match
  import jb_clk_pkg::*;
#(
  parameter int NUM_WIN   = 2,
  parameter int ADDR_W    = 16,
  parameter int WAIT_BITS = 3,
  localparam int IDX_W    = clog2_min1(NUM_WIN)
) (
  input  logic [ADDR_W-1:0]           adr,
  input  logic [NUM_WIN*ADDR_W-1:0]    win_base,
  input  logic [NUM_WIN*ADDR_W-1:0]    win_mask,
  input  logic [NUM_WIN*WAIT_BITS-1:0] win_wait,
  input  logic [NUM_WIN-1:0]           win_en,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);

  logic [NUM_WIN-1:0] win_hit;

  // A window with a zero wait count can never stretch, so it never hits
  for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_cmp
    assign win_hit[gi] = win_en[gi]
                      && (win_wait[gi*WAIT_BITS +: WAIT_BITS] != '0)
                      && (((adr ^ win_base[gi*ADDR_W +: ADDR_W])
                           & win_mask[gi*ADDR_W +: ADDR_W]) == '0);
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/jb_bus_clkgen.sv
// CPU phase clock / peripheral clock generator with power-on hold-off
// and per-window wait-state stretching of the high phase.
module jb_bus_clkgen
  import jb_clk_pkg::*;
#(
  parameter int DIV       = 1,
  parameter int POR_BITS  = 16,
  parameter int NUM_WIN   = 2,
  parameter int ADDR_W    = 16,
  parameter int WAIT_BITS = 3,
  localparam int IDX_W    = clog2_min1(NUM_WIN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            adr,
  input  logic [NUM_WIN*ADDR_W-1:0]    win_base,
  input  logic [NUM_WIN*ADDR_W-1:0]    win_mask,
  input  logic [NUM_WIN*WAIT_BITS-1:0] win_wait,
  input  logic [NUM_WIN-1:0]           win_en,
  output logic                         sys_clk,
  output logic                         via_clk,
  output logic                         run,
  output logic                         stretching,
  output logic [IDX_W-1:0]             stretch_win
);

  localparam int PH_W = clog2_min1(DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

  clk_state_t           state_reg, state_next;
  logic [POR_BITS-1:0]  por_cnt_reg, por_cnt_next;
  logic [PH_W-1:0]      phase_reg, phase_next;
  logic [WAIT_BITS-1:0] wait_cnt_reg, wait_cnt_next;
  logic                 sys_clk_reg, sys_clk_next;
  logic                 via_clk_reg, via_clk_next;
  logic                 run_reg, run_next;
  logic                 stretching_reg, stretching_next;
  logic [IDX_W-1:0]     stretch_win_reg, stretch_win_next;

  logic                 tc;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;

  jb_win_match #(
    .NUM_WIN  (NUM_WIN),
    .ADDR_W   (ADDR_W),
    .WAIT_BITS(WAIT_BITS)
  ) u_match (
    .adr     (adr),
    .win_base(win_base),
    .win_mask(win_mask),
    .win_wait(win_wait),
    .win_en  (win_en),
    .hit     (hit),
    .idx     (hit_idx)
  );

  assign tc = run_reg && (phase_reg == PH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= POR;
      por_cnt_reg     <= '0;
      phase_reg       <= '0;
      wait_cnt_reg    <= '0;
      sys_clk_reg     <= 1'b0;
      via_clk_reg     <= 1'b0;
      run_reg         <= 1'b0;
      stretching_reg  <= 1'b0;
      stretch_win_reg <= '0;
    end else begin
      state_reg       <= state_next;
      por_cnt_reg     <= por_cnt_next;
      phase_reg       <= phase_next;
      wait_cnt_reg    <= wait_cnt_next;
      sys_clk_reg     <= sys_clk_next;
      via_clk_reg     <= via_clk_next;
      run_reg         <= run_next;
      stretching_reg  <= stretching_next;
      stretch_win_reg <= stretch_win_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    por_cnt_next     = por_cnt_reg;
    phase_next       = phase_reg;
    wait_cnt_next    = wait_cnt_reg;
    sys_clk_next     = sys_clk_reg;
    via_clk_next     = via_clk_reg;
    run_next         = run_reg;
    stretching_next  = stretching_reg;
    stretch_win_next = stretch_win_reg;

    if (run_reg) phase_next = tc ? '0 : phase_reg + 1'b1;
    if (tc) via_clk_next = ~via_clk_reg;

    case (state_reg)
      POR: begin
        por_cnt_next = por_cnt_reg + 1'b1;
        if (&por_cnt_reg) begin
          run_next   = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        // Window inputs are only looked at on the rising edge of sys_clk
        if (tc) begin
          sys_clk_next = 1'b1;
          if (hit) begin
            wait_cnt_next    = win_wait[int'(hit_idx)*WAIT_BITS +: WAIT_BITS];
            stretch_win_next = hit_idx;
            stretching_next  = 1'b1;
            state_next       = HIGH_S;
          end else begin
            state_next = HIGH;
          end
        end
      end
      HIGH: begin
        if (tc) begin
          sys_clk_next = 1'b0;
          state_next   = LOW;
        end
      end
      HIGH_S: begin
        if (tc) begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
          if (wait_cnt_reg == WAIT_BITS'(1)) begin
            stretching_next = 1'b0;
            state_next      = HIGH;
          end
        end
      end
      default: state_next = POR;
    endcase
  end

  assign sys_clk     = sys_clk_reg;
  assign via_clk     = via_clk_reg;
  assign run         = run_reg;
  assign stretching  = stretching_reg;
  assign stretch_win = stretch_win_reg;

endmodule

// File: tb/tb_jb_bus_clkgen.sv
// Scoreboard bench for jb_bus_clkgen: one instance at DIV=1 and one at DIV=2,
// each with its own stimulus process, reference model and pulse monitor.
module tb_jb_bus_clkgen;
  import jb_clk_pkg::*;

  localparam int POR_BITS  = 4;
  localparam int NUM_WIN   = 2;
  localparam int ADDR_W    = 16;
  localparam int WAIT_BITS = 3;
  localparam int SW        = clog2_min1(NUM_WIN);
  localparam int NPULSE    = 40;

  typedef struct {
    int high;
    int str;
    int win;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: first enabled window with nonzero wait whose masked bits match
  function automatic int model_hit(input int a, input int base[NUM_WIN], input int mask[NUM_WIN],
                                   input int wt[NUM_WIN], input bit en[NUM_WIN]);
    for (int i = 0; i < NUM_WIN; i++)
      if (en[i] && wt[i] != 0 && (((a ^ base[i]) & mask[i]) == 0)) return i;
    return -1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_div
    localparam int D   = gi + 1;
    localparam int LIM = 40 * D + 40;

    logic                         rst;
    logic [ADDR_W-1:0]            adr;
    logic [NUM_WIN*ADDR_W-1:0]    win_base, win_mask;
    logic [NUM_WIN*WAIT_BITS-1:0] win_wait;
    logic [NUM_WIN-1:0]           win_en;
    logic                         sys_clk, via_clk, run, stretching;
    logic [SW-1:0]                stretch_win;

    int   wb[NUM_WIN], wm[NUM_WIN], ww[NUM_WIN];
    bit   we[NUM_WIN];
    int   a;
    exp_t q[$];
    bit   mon_en = 1'b0;
    bit   fin = 1'b0;

    assign adr = a[ADDR_W-1:0];
    for (genvar gw = 0; gw < NUM_WIN; gw++) begin : g_pack
      assign win_base[gw*ADDR_W +: ADDR_W]       = wb[gw][ADDR_W-1:0];
      assign win_mask[gw*ADDR_W +: ADDR_W]       = wm[gw][ADDR_W-1:0];
      assign win_wait[gw*WAIT_BITS +: WAIT_BITS] = ww[gw][WAIT_BITS-1:0];
      assign win_en[gw]                          = we[gw];
    end

    jb_bus_clkgen #(
      .DIV(D), .POR_BITS(POR_BITS), .NUM_WIN(NUM_WIN), .ADDR_W(ADDR_W), .WAIT_BITS(WAIT_BITS)
    ) dut (
      .clk(clk), .rst(rst), .adr(adr), .win_base(win_base), .win_mask(win_mask),
      .win_wait(win_wait), .win_en(win_en), .sys_clk(sys_clk), .via_clk(via_clk),
      .run(run), .stretching(stretching), .stretch_win(stretch_win)
    );

    // Monitor: measures each high/low phase and via half-period, pops at every fall
    initial begin
      bit en_d, prev_sys, prev_via, have_rise, fall_seen, via_seen;
      int hi, lo, st, vc;
      exp_t e;
      en_d = 0; prev_sys = 0; prev_via = 0; have_rise = 0; fall_seen = 0; via_seen = 0;
      hi = 0; lo = 0; st = 0; vc = 0;
      forever begin
        @(negedge clk);
        if (mon_en && !en_d) begin
          prev_sys = sys_clk; prev_via = via_clk;
          have_rise = 0; fall_seen = 0; via_seen = 0;
          hi = 0; lo = 0; st = 0; vc = 0;
        end else if (mon_en) begin
          vc++;
          if (via_clk != prev_via) begin
            if (via_seen) check($sformatf("d%0d_via_half", D), vc, D);
            via_seen = 1; vc = 0;
          end
          if (stretching) st++;
          if (sys_clk && !prev_sys) begin
            if (fall_seen) check($sformatf("d%0d_low_len", D), lo, D);
            have_rise = 1; hi = 0;
          end
          if (!sys_clk && prev_sys) begin
            if (have_rise) begin
              if (q.size() == 0) check($sformatf("d%0d_sb_underflow", D), 1, 0);
              else begin
                e = q.pop_front();
                $display("d%0d pulse: high=%0d stretch=%0d win=%0d (exp %0d/%0d/%0d)",
                         D, hi, st, stretch_win, e.high, e.str, e.win);
                check($sformatf("d%0d_high_len", D), hi, e.high);
                check($sformatf("d%0d_stretch_len", D), st, e.str);
                check($sformatf("d%0d_stretch_win", D), int'(stretch_win), e.win);
              end
            end
            fall_seen = 1; lo = 0; st = 0;
          end
          if (sys_clk) hi++; else lo++;
          prev_sys = sys_clk; prev_via = via_clk;
        end
        en_d = mon_en;
      end
    end

    // Stimulus
    initial begin
      int fr, fs, fv, t, hit, j, exp_win;
      exp_t e;
      rst = 1'b1;
      a = 0;
      exp_win = 0;
      for (int i = 0; i < NUM_WIN; i++) begin wb[i] = 0; wm[i] = 0; ww[i] = 0; we[i] = 0; end

      for (int pass = 0; pass < 2; pass++) begin
        if (pass == 1) begin
          we = '{1, 0}; wb = '{32'h9F40, 0}; wm = '{32'hFFFE, 0}; ww = '{3, 0}; a = 32'h9F41;
          t = 0;
          while (!sys_clk && t < LIM) begin @(negedge clk); t++; end
          @(negedge clk);
          check($sformatf("d%0d_mid_stretch", D), int'(stretching), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("d%0d_rst_sys", D), int'(sys_clk), 0);
        check($sformatf("d%0d_rst_via", D), int'(via_clk), 0);
        check($sformatf("d%0d_rst_run", D), int'(run), 0);
        check($sformatf("d%0d_rst_stretching", D), int'(stretching), 0);
        check($sformatf("d%0d_rst_stretch_win", D), int'(stretch_win), 0);
        rst = 1'b0;
        fr = -1; fs = -1; fv = -1;
        for (int ed = 1; ed <= 20 + D; ed++) begin
          @(negedge clk);
          if (run && fr < 0) fr = ed;
          if (sys_clk && fs < 0) fs = ed;
          if (via_clk && fv < 0) fv = ed;
        end
        $display("d%0d por pass %0d: run@%0d sys@%0d via@%0d", D, pass, fr, fs, fv);
        check($sformatf("d%0d_por_run_edge", D), fr, 1 << POR_BITS);
        check($sformatf("d%0d_first_sys_edge", D), fs, (1 << POR_BITS) + D);
        check($sformatf("d%0d_first_via_edge", D), fv, (1 << POR_BITS) + D);

        if (pass == 0) begin
          t = 0;
          while (!sys_clk && t < LIM) begin @(negedge clk); t++; end
          #1 mon_en = 1'b1;
          while (sys_clk && t < LIM) begin @(negedge clk); t++; end
          if (t >= LIM) check($sformatf("d%0d_sync_timeout", D), t, 0);

          for (int k = 0; k < NPULSE; k++) begin
            case (k)
              0: begin we = '{1, 0}; wb = '{32'h9F40, 0}; wm = '{32'hFFFE, 0}; ww = '{3, 0}; a = 32'h9F41; end
              1: begin we = '{1, 1}; wb = '{32'h9F00, 32'h9F40}; wm = '{32'hFF00, 32'hFFFE}; ww = '{1, 5}; a = 32'h9F40; end
              2: begin we = '{0, 1}; wb = '{32'h9F00, 32'h9F40}; wm = '{32'hFF00, 32'hFFFE}; ww = '{1, 5}; a = 32'h9F40; end
              3: begin we = '{0, 0}; a = int'($urandom & 32'hFFFF); end
              default: begin
                for (int i = 0; i < NUM_WIN; i++) begin
                  wb[i] = int'($urandom & 32'hFFFF);
                  wm[i] = ($urandom_range(0, 1) == 1) ? 32'hFFF0 : int'($urandom & 32'hFFFF);
                  ww[i] = int'($urandom_range(0, 7));
                  we[i] = ($urandom_range(0, 3) != 0);
                end
                if (k % 4 == 0) begin wb[1] = wb[0]; wm[1] = wm[0]; end
                j = int'($urandom_range(0, NUM_WIN));
                if (j < NUM_WIN) a = (wb[j] & wm[j]) | (int'($urandom) & ~wm[j] & 32'hFFFF);
                else a = int'($urandom & 32'hFFFF);
              end
            endcase
            hit = model_hit(a, wb, wm, ww, we);
            if (hit >= 0) begin
              exp_win = hit;
              e.high = D * (1 + ww[hit]); e.str = D * ww[hit]; e.win = hit;
            end else begin
              e.high = D; e.str = 0; e.win = exp_win;
            end
            q.push_back(e);
            t = 0;
            while (!sys_clk && t < LIM) begin @(negedge clk); t++; end
            while (sys_clk && t < LIM) begin @(negedge clk); t++; end
            if (t >= LIM) begin
              check($sformatf("d%0d_pulse_timeout", D), t, 0);
              break;
            end
          end
          #1 mon_en = 1'b0;
          check($sformatf("d%0d_sb_drain", D), q.size(), 0);
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 50000; t++) begin
      if (g_div[0].fin && g_div[1].fin) break;
      @(negedge clk);
    end
    if (!(g_div[0].fin && g_div[1].fin)) check("global_timeout", 0, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
